// File: rtl/bus_seq_pkg.sv
// Shared definitions for the bus scenario sequencer.
//  - seq_state_t : FSM state encoding, also exported on state_out
//  - DELAY_W     : width of the per-step gap delay field
//  - clog2_min1  : index width helper that never returns 0
//  - step_bits   : total step-table word width for a given parameter set
// Step word layout, MSB to LSB: {last, delay, mid, rd, burst, addr, data}.
package bus_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } seq_state_t;

  localparam int DELAY_W = 8;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int step_bits(input int mid_w, input int burst_w,
                                   input int addr_w, input int data_w);
    return 1 + DELAY_W + mid_w + 1 + burst_w + addr_w + data_w;
  endfunction

endpackage

// File: rtl/bus_seq_step_ram.sv
// Step table storage: DEPTH x WIDTH, one write port, one registered read port.
// Contents are deliberately not reset; the table must be reprogrammed after reset.
//  clk   : clock
//  we    : write strobe, waddr/wdata : write index and word
//  re    : read enable, raddr : read index
//  rdata : registered read word, updated only when re is high
module bus_seq_step_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 36,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bus_scenario_sequencer.sv
// Programmable stimulus sequencer: walks a loadable step table and drives one
// of NUM_MASTERS bus master ports per step.
//  clk, reset        : clock, asynchronous active-low reset
//  start, start_idx  : begin a run at start_idx (only honoured in IDLE)
//  prog_we/addr/data : step table write port (only honoured in IDLE)
//  m_request         : per-master busy; step completes when the selected one is low
//  m_rvalid, m_rdata : per-master read return, compared against step data on reads
//  m_enable ... m_data_in : per-master stimulus outputs
//  state_out, step_out, busy, done, error, mismatch_cnt : status
// Master-side protocol: m_enable is a level held for SETUP_CYCLES; the master
// answers by holding m_request high while busy. Each cycle m_rvalid[i] is high
// is one read beat (no back-pressure); beats are only inspected during WAIT.
module bus_scenario_sequencer
  import bus_seq_pkg::*;
#(
  parameter  int NUM_MASTERS  = 2,
  parameter  int DATA_W       = 8,
  parameter  int ADDR_W       = 14,
  parameter  int BURST_W      = 3,
  parameter  int NUM_STEPS    = 16,
  parameter  int SETUP_CYCLES = 3,
  parameter  int TIMEOUT      = 255,
  localparam int MID_W        = clog2_min1(NUM_MASTERS),
  localparam int STEP_W       = clog2_min1(NUM_STEPS),
  localparam int STEP_BITS    = step_bits(MID_W, BURST_W, ADDR_W, DATA_W)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [STEP_W-1:0]              start_idx,
  input  logic                           prog_we,
  input  logic [STEP_W-1:0]              prog_addr,
  input  logic [STEP_BITS-1:0]           prog_data,
  input  logic [NUM_MASTERS-1:0]         m_request,
  input  logic [NUM_MASTERS-1:0]         m_rvalid,
  input  logic [NUM_MASTERS*DATA_W-1:0]  m_rdata,
  output logic [NUM_MASTERS-1:0]         m_enable,
  output logic [NUM_MASTERS-1:0]         m_read_en,
  output logic [NUM_MASTERS*BURST_W-1:0] m_burst_mode,
  output logic [NUM_MASTERS*ADDR_W-1:0]  m_addr_in,
  output logic [NUM_MASTERS*DATA_W-1:0]  m_data_in,
  output logic [2:0]                     state_out,
  output logic [STEP_W-1:0]              step_out,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic [7:0]                     mismatch_cnt
);

  localparam int ADDR_LSB  = DATA_W;
  localparam int BURST_LSB = ADDR_LSB + ADDR_W;
  localparam int RD_BIT    = BURST_LSB + BURST_W;
  localparam int MID_LSB   = RD_BIT + 1;
  localparam int DELAY_LSB = MID_LSB + MID_W;
  localparam int LAST_BIT  = DELAY_LSB + DELAY_W;
  localparam int CNT_W     = 16;

  seq_state_t             state_q, state_d;
  logic [STEP_W-1:0]      step_q, step_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   error_q, error_d;
  logic [7:0]             mm_q, mm_d;
  logic [STEP_BITS-1:0]   step_word;

  // Table read is issued in FETCH; the registered word stays stable until the
  // next FETCH, so the step fields are taken straight from the RAM output.
  bus_seq_step_ram #(.DEPTH(NUM_STEPS), .WIDTH(STEP_BITS), .AW(STEP_W)) u_ram (
    .clk   (clk),
    .we    (prog_we && (state_q == ST_IDLE)),
    .waddr (prog_addr),
    .wdata (prog_data),
    .re    (state_q == ST_FETCH),
    .raddr (step_q),
    .rdata (step_word)
  );

  logic                st_last, st_rd;
  logic [DELAY_W-1:0]  st_delay;
  logic [MID_W-1:0]    st_mid;
  logic [BURST_W-1:0]  st_burst;
  logic [ADDR_W-1:0]   st_addr;
  logic [DATA_W-1:0]   st_data;

  assign st_last  = step_word[LAST_BIT];
  assign st_delay = step_word[DELAY_LSB +: DELAY_W];
  assign st_mid   = step_word[MID_LSB +: MID_W];
  assign st_rd    = step_word[RD_BIT];
  assign st_burst = step_word[BURST_LSB +: BURST_W];
  assign st_addr  = step_word[ADDR_LSB +: ADDR_W];
  assign st_data  = step_word[0 +: DATA_W];

  logic              mid_ok, req_sel, rvalid_sel, drive;
  logic [DATA_W-1:0] rdata_sel;

  assign mid_ok = (int'(st_mid) < NUM_MASTERS);
  assign drive  = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

  // Master port mux: an out-of-range mid matches no port, so nothing is driven.
  always_comb begin
    m_enable     = '0;
    m_read_en    = '0;
    m_burst_mode = '0;
    m_addr_in    = '0;
    m_data_in    = '0;
    req_sel      = 1'b0;
    rvalid_sel   = 1'b0;
    rdata_sel    = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (int'(st_mid) == i) begin
        req_sel    = m_request[i];
        rvalid_sel = m_rvalid[i];
        rdata_sel  = m_rdata[i*DATA_W +: DATA_W];
        if (drive) begin
          m_enable[i]                     = (state_q == ST_ISSUE);
          m_read_en[i]                    = st_rd;
          m_burst_mode[i*BURST_W +: BURST_W] = st_burst;
          m_addr_in[i*ADDR_W +: ADDR_W]   = st_addr;
          m_data_in[i*DATA_W +: DATA_W]   = st_data;
        end
      end
    end
  end

  logic finish_step, end_step;

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    cnt_d       = cnt_q;
    error_d     = error_q;
    mm_d        = mm_q;
    finish_step = 1'b0;
    end_step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          step_d  = start_idx;
          cnt_d   = '0;
          error_d = 1'b0;
          mm_d    = '0;
        end
      end
      ST_FETCH: begin
        state_d = ST_ISSUE;
        cnt_d   = '0;
      end
      ST_ISSUE: begin
        if (cnt_q == CNT_W'(SETUP_CYCLES - 1)) begin
          cnt_d = '0;
          if (mid_ok) state_d = ST_WAIT;
          else        finish_step = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (st_rd && rvalid_sel && (rdata_sel != st_data) && (mm_q != 8'hFF))
          mm_d = mm_q + 8'd1;
        if (!req_sel) begin
          finish_step = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == CNT_W'(st_delay) - CNT_W'(1)) end_step = 1'b1;
        else                                       cnt_d = cnt_q + CNT_W'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A zero delay skips GAP entirely and resolves the step end immediately.
    if (finish_step) begin
      cnt_d = '0;
      if (st_delay != '0) state_d = ST_GAP;
      else                end_step = 1'b1;
    end
    // The table never wraps: the final entry ends the run even without last.
    if (end_step) begin
      if (st_last || (int'(step_q) == NUM_STEPS - 1)) begin
        state_d = ST_DONE;
      end else begin
        step_d  = step_q + STEP_W'(1);
        state_d = ST_FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      cnt_q   <= '0;
      error_q <= 1'b0;
      mm_q    <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
      mm_q    <= mm_d;
    end
  end

  assign state_out    = state_q;
  assign step_out     = step_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign error        = error_q;
  assign mismatch_cnt = mm_q;

endmodule

// File: tb/tb_bus_scenario_sequencer.sv
module tb_bus_scenario_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  start_idx;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [35:0] prog_data;
  logic [1:0]  m_request;
  logic [1:0]  m_rvalid;
  logic [15:0] m_rdata;
  logic [1:0]  m_enable;
  logic [1:0]  m_read_en;
  logic [5:0]  m_burst_mode;
  logic [27:0] m_addr_in;
  logic [15:0] m_data_in;
  logic [2:0]  state_out;
  logic [3:0]  step_out;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  mismatch_cnt;

  int checks   = 0;
  int failures = 0;

  bus_scenario_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .start_idx    (start_idx),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .m_request    (m_request),
    .m_rvalid     (m_rvalid),
    .m_rdata      (m_rdata),
    .m_enable     (m_enable),
    .m_read_en    (m_read_en),
    .m_burst_mode (m_burst_mode),
    .m_addr_in    (m_addr_in),
    .m_data_in    (m_data_in),
    .state_out    (state_out),
    .step_out     (step_out),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .mismatch_cnt (mismatch_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // driver tasks: inputs change and outputs are sampled 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] mk_step(input logic last, input logic [7:0] delay,
                                          input logic mid, input logic rd,
                                          input logic [2:0] burst, input logic [13:0] addr,
                                          input logic [7:0] data);
    return {last, delay, mid, rd, burst, addr, data};
  endfunction

  task automatic prog(input logic [3:0] a, input logic [35:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic kick(input logic [3:0] idx);
    start = 1'b1; start_idx = idx;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 0; start_idx = 0; prog_we = 0; prog_addr = 0; prog_data = 0;
    m_request = 0; m_rvalid = 0; m_rdata = 0;
    tick(); tick();
    checks++; if ({m_enable, m_read_en, m_burst_mode, m_addr_in, m_data_in} !== '0) begin failures++; $display("FAIL rst_mports got=%0h exp=0", {m_enable, m_read_en, m_burst_mode, m_addr_in, m_data_in}); end
    checks++; if ({state_out, step_out, busy, done, error, mismatch_cnt} !== '0) begin failures++; $display("FAIL rst_status got=%0h exp=0", {state_out, step_out, busy, done, error, mismatch_cnt}); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    m_request = 2'b00;
    prog(4'd0, mk_step(1'b1, 8'd0, 1'b0, 1'b0, 3'd0, 14'd5012, 8'd78));
    kick(4'd0);
    checks++; if (state_out !== 3'd1 || busy !== 1'b1) begin failures++; $display("FAIL w_fetch got=%0d/%0b exp=1/1", state_out, busy); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (state_out !== 3'd2 || m_enable !== 2'b01 || m_read_en !== 2'b00) begin failures++; $display("FAIL w_issue%0d got=%0d/%0b/%0b exp=2/01/00", c, state_out, m_enable, m_read_en); end
      checks++; if (m_addr_in !== {14'd0, 14'd5012} || m_data_in !== {8'd0, 8'd78}) begin failures++; $display("FAIL w_fields%0d got=%0h/%0h exp=%0h/%0h", c, m_addr_in, m_data_in, {14'd0, 14'd5012}, {8'd0, 8'd78}); end
    end
    tick();
    checks++; if (state_out !== 3'd3 || m_enable !== 2'b00 || m_addr_in[13:0] !== 14'd5012) begin failures++; $display("FAIL w_wait got=%0d/%0b/%0d exp=3/00/5012", state_out, m_enable, m_addr_in[13:0]); end
    tick();
    checks++; if (done !== 1'b1 || state_out !== 3'd5 || error !== 1'b0) begin failures++; $display("FAIL w_done got=%0b/%0d/%0b exp=1/5/0", done, state_out, error); end
    checks++; if (m_addr_in !== '0) begin failures++; $display("FAIL w_done_idle_out got=%0h exp=0", m_addr_in); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL w_idle got=%0b/%0b exp=0/0", done, busy); end
  endtask

  task automatic test_split_gap();
    int w = -1, r = -1, gaps = 0, dn = 0, both = 0;
    logic [13:0] a1 = '0;
    logic [7:0]  d1 = '0;
    logic [2:0]  b1 = '0;
    m_request = 2'b00;
    prog(4'd0, mk_step(1'b0, 8'd8, 1'b0, 1'b0, 3'd0, 14'd5012, 8'd78));
    prog(4'd1, mk_step(1'b1, 8'd0, 1'b1, 1'b0, 3'd2, 14'd1001, 8'd62));
    kick(4'd0);
    for (int c = 0; c < 40; c++) begin
      if (state_out == 3'd3 && step_out == 4'd0) w = c;
      if (state_out == 3'd4) gaps++;
      if (m_enable == 2'b11) both++;
      if (m_enable[1] && r < 0) begin
        r = c; a1 = m_addr_in[27:14]; d1 = m_data_in[15:8]; b1 = m_burst_mode[5:3];
      end
      if (done) dn++;
      tick();
    end
    checks++; if (r < 0 || w < 0 || (r - w) != 10) begin failures++; $display("FAIL split_spacing got=%0d exp=10", r - w); end
    checks++; if (gaps != 8) begin failures++; $display("FAIL split_gaps got=%0d exp=8", gaps); end
    checks++; if (a1 !== 14'd1001 || d1 !== 8'd62 || b1 !== 3'd2) begin failures++; $display("FAIL split_m1_fields got=%0d/%0d/%0d exp=1001/62/2", a1, d1, b1); end
    checks++; if (dn != 1 || both != 0) begin failures++; $display("FAIL split_done got=%0d/%0d exp=1/0", dn, both); end
  endtask

  task automatic do_read(input logic [7:0] rd_val, input logic [7:0] exp_mm);
    m_request = 2'b01;
    prog(4'd0, mk_step(1'b1, 8'd0, 1'b0, 1'b1, 3'd1, 14'd5097, 8'd101));
    kick(4'd0);
    for (int c = 0; c < 3; c++) tick();
    checks++; if (m_read_en !== 2'b01 || m_enable !== 2'b01 || m_burst_mode[2:0] !== 3'd1) begin failures++; $display("FAIL rd_issue got=%0b/%0b/%0d exp=01/01/1", m_read_en, m_enable, m_burst_mode[2:0]); end
    tick();
    checks++; if (state_out !== 3'd3 || m_enable !== 2'b00 || m_read_en !== 2'b01) begin failures++; $display("FAIL rd_wait got=%0d/%0b/%0b exp=3/00/01", state_out, m_enable, m_read_en); end
    // the non-selected master also returns garbage, which must be ignored
    m_rvalid = 2'b11; m_rdata = {8'h55, rd_val};
    tick();
    m_rvalid = 2'b00; m_request = 2'b00;
    checks++; if (mismatch_cnt !== exp_mm) begin failures++; $display("FAIL rd_mm_%0d got=%0d exp=%0d", rd_val, mismatch_cnt, exp_mm); end
    tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL rd_done got=%0b exp=1", done); end
    tick();
    checks++; if (mismatch_cnt !== exp_mm || busy !== 1'b0) begin failures++; $display("FAIL rd_hold_%0d got=%0d/%0b exp=%0d/0", rd_val, mismatch_cnt, busy, exp_mm); end
  endtask

  task automatic test_read_check();
    do_read(8'd100, 8'd1);
    do_read(8'd101, 8'd0);
  endtask

  task automatic test_timeout();
    m_request = 2'b01;
    prog(4'd0, mk_step(1'b1, 8'd0, 1'b0, 1'b0, 3'd0, 14'd42, 8'd9));
    kick(4'd0);
    for (int c = 0; c < 4; c++) tick();
    repeat (254) tick();
    checks++; if (state_out !== 3'd3 || error !== 1'b0) begin failures++; $display("FAIL to_pre got=%0d/%0b exp=3/0", state_out, error); end
    tick();
    checks++; if (state_out !== 3'd5 || error !== 1'b1 || done !== 1'b1) begin failures++; $display("FAIL to_fire got=%0d/%0b/%0b exp=5/1/1", state_out, error, done); end
    tick();
    checks++; if (busy !== 1'b0 || error !== 1'b1) begin failures++; $display("FAIL to_sticky got=%0b/%0b exp=0/1", busy, error); end
    m_request = 2'b00;
    kick(4'd0);
    checks++; if (error !== 1'b0 || state_out !== 3'd1) begin failures++; $display("FAIL to_clear got=%0b/%0d exp=0/1", error, state_out); end
    for (int c = 0; c < 5; c++) tick();
    checks++; if (done !== 1'b1 || error !== 1'b0) begin failures++; $display("FAIL to_rerun got=%0b/%0b exp=1/0", done, error); end
    tick();
  endtask

  task automatic test_table_end();
    int en0 = 0, en1 = 0, dn = 0, bad_step = 0;
    m_request = 2'b00;
    prog(4'd15, mk_step(1'b0, 8'd0, 1'b0, 1'b0, 3'd0, 14'd15, 8'd15));
    prog(4'd0,  mk_step(1'b1, 8'd0, 1'b1, 1'b0, 3'd0, 14'd7,  8'd7));
    kick(4'd15);
    for (int c = 0; c < 12; c++) begin
      tick();
      if (m_enable[0]) begin en0++; if (step_out != 4'd15) bad_step++; end
      if (m_enable[1]) en1++;
      if (done) dn++;
    end
    checks++; if (en0 != 3 || en1 != 0 || bad_step != 0) begin failures++; $display("FAIL end_enables got=%0d/%0d/%0d exp=3/0/0", en0, en1, bad_step); end
    checks++; if (dn != 1 || state_out !== 3'd0) begin failures++; $display("FAIL end_done got=%0d/%0d exp=1/0", dn, state_out); end
  endtask

  task automatic test_reset_midrun();
    m_request = 2'b01;
    prog(4'd0, mk_step(1'b1, 8'd0, 1'b1, 1'b0, 3'd3, 14'd1001, 8'd62));
    kick(4'd0);
    tick();
    checks++; if (m_enable !== 2'b10 || m_addr_in[27:14] !== 14'd1001 || m_burst_mode[5:3] !== 3'd3) begin failures++; $display("FAIL mr_issue got=%0b/%0d/%0d exp=10/1001/3", m_enable, m_addr_in[27:14], m_burst_mode[5:3]); end
    // write while busy must be dropped
    prog(4'd0, mk_step(1'b1, 8'd0, 1'b0, 1'b0, 3'd0, 14'd3333, 8'd1));
    reset = 1'b0;
    #1;
    checks++; if ({m_enable, m_read_en, m_burst_mode, m_addr_in, m_data_in} !== '0) begin failures++; $display("FAIL mr_ports got=%0h exp=0", {m_enable, m_read_en, m_burst_mode, m_addr_in, m_data_in}); end
    checks++; if (state_out !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL mr_state got=%0d/%0b/%0b exp=0/0/0", state_out, busy, done); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL mr_nodone got=%0b exp=0", done); end
    end
    reset = 1'b1;
    m_request = 2'b00;
    tick();
    kick(4'd0);
    tick();
    checks++; if (m_enable !== 2'b10 || m_addr_in[27:14] !== 14'd1001) begin failures++; $display("FAIL mr_table got=%0b/%0d exp=10/1001", m_enable, m_addr_in[27:14]); end
    for (int c = 0; c < 4; c++) tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL mr_rerun got=%0b exp=1", done); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_split_gap();
    test_read_check();
    test_timeout();
    test_table_end();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
